// File: rtl/uart_pkg.sv
// Shared definitions for the packet UART receiver: mode-word fields, baud divisor
// arithmetic, parity helper and FSM state encodings.
package uart_pkg;

    localparam logic [1:0] BAUD_4800  = 2'b00;
    localparam logic [1:0] BAUD_9600  = 2'b01;
    localparam logic [1:0] BAUD_19200 = 2'b10;
    localparam logic [1:0] BAUD_57600 = 2'b11;

    localparam int MODE_PAR_EN   = 0;
    localparam int MODE_PAR_ODD  = 1;
    localparam int MODE_ONE_STOP = 5;

    typedef enum logic [2:0] {
        BIT_IDLE, BIT_START, BIT_DATA, BIT_PARITY, BIT_STOP1, BIT_STOP2
    } bit_state_t;

    typedef enum logic [1:0] {
        PKT_HDR_LO, PKT_HDR_HI, PKT_PAYLOAD
    } pkt_state_t;

    function automatic int baud_rate(input logic [1:0] sel);
        case (sel)
            BAUD_4800:  return 4800;
            BAUD_9600:  return 9600;
            BAUD_19200: return 19200;
            default:    return 57600;
        endcase
    endfunction

    // Rounded clocks-per-oversample-tick for one baud selection.
    function automatic logic [15:0] baud_divisor(input int clk_hz, input int os, input logic [1:0] sel);
        int d;
        d = baud_rate(sel) * os;
        return 16'((clk_hz + d / 2) / d);
    endfunction

    function automatic logic [2:0] last_bit_index(input logic [1:0] bits_sel);
        return 3'd4 + {1'b0, bits_sel};
    endfunction

    // High when data+parity ones-count disagrees with the selected polarity.
    function automatic logic parity_error(input logic [7:0] data, input logic par, input logic odd);
        return ^{data, par, odd};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable divisor counter producing the oversample tick; restart realigns it to a start edge.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;

    // Divide the clock down to one tick per divisor cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r >= divisor - DIV_W'(1)) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_packet.sv
// Oversampling UART receiver with runtime mode word; strips a 2-byte little-endian
// length header and streams payload bytes with last and error flags.
module uart_rx_packet
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int LEN_W      = 16
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] Mode,
    input  logic       RXD,
    output logic [7:0] DATA_OUT,
    output logic       Valid,
    input  logic       Ready,
    output logic       Last,
    output logic       Parity_err,
    output logic       Frame_err,
    output logic       Overrun,
    output logic       RTS,
    output logic       Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [15:0] DIV_0 = baud_divisor(CLK_HZ, OVERSAMPLE, BAUD_4800);
    localparam logic [15:0] DIV_1 = baud_divisor(CLK_HZ, OVERSAMPLE, BAUD_9600);
    localparam logic [15:0] DIV_2 = baud_divisor(CLK_HZ, OVERSAMPLE, BAUD_19200);
    localparam logic [15:0] DIV_3 = baud_divisor(CLK_HZ, OVERSAMPLE, BAUD_57600);

    logic rxd_meta_r, rxd_sync_r, rxd_prev_r;
    logic [7:0] mode_r;
    bit_state_t bit_state_r, bit_state_s;
    logic [CW-1:0] tick_cnt_r;
    logic [2:0] bit_idx_r;
    logic [7:0] data_r;
    logic samp_a_r, samp_c_r, perr_r, ferr_r;
    logic tick_s, fall_s, start_s, at_a_s, at_c_s, at_b_s, bit_end_s, maj_s;
    logic done_s, ferr_s, bad_s, final_s, unused_mode_s;
    logic [15:0] div_s;
    logic [2:0] last_idx_s;

    pkt_state_t pkt_state_r, pkt_state_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic [7:0] dout_r, dout_s;
    logic valid_r, valid_s, last_r, last_s, perr_o_r, perr_o_s, ferr_o_r, ferr_o_s;
    logic overrun_r, overrun_s, rts_r, busy_r;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= RXD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    assign fall_s        = rxd_prev_r & ~rxd_sync_r;
    assign start_s       = (bit_state_r == BIT_IDLE) && fall_s;
    assign unused_mode_s = mode_r[4];
    assign last_idx_s    = last_bit_index(mode_r[3:2]);

    // Divisor follows the mode latched for the current frame.
    always_comb begin
        div_s = DIV_3;
        case (mode_r[7:6])
            BAUD_4800:  div_s = DIV_0;
            BAUD_9600:  div_s = DIV_1;
            BAUD_19200: div_s = DIV_2;
            default:    div_s = DIV_3;
        endcase
    end

    uart_baud_gen #(.DIV_W(16)) u_baud_gen (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .restart (start_s),
        .divisor (div_s),
        .tick    (tick_s)
    );

    assign at_a_s    = tick_s && (tick_cnt_r == CW'(OVERSAMPLE / 2 - 2));
    assign at_c_s    = tick_s && (tick_cnt_r == CW'(OVERSAMPLE / 2 - 1));
    assign at_b_s    = tick_s && (tick_cnt_r == CW'(OVERSAMPLE / 2));
    assign bit_end_s = tick_s && (tick_cnt_r == CW'(OVERSAMPLE - 1));
    assign maj_s     = (samp_a_r & samp_c_r) | (samp_a_r & rxd_sync_r) | (samp_c_r & rxd_sync_r);
    assign done_s    = at_c_s && (((bit_state_r == BIT_STOP1) && mode_r[MODE_ONE_STOP]) ||
                                  (bit_state_r == BIT_STOP2));
    assign ferr_s    = ferr_r | ~rxd_sync_r;
    assign bad_s     = perr_r | ferr_s;

    // Bit FSM state register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) bit_state_r <= BIT_IDLE;
        else          bit_state_r <= bit_state_s;
    end

    // Bit FSM next state.
    always_comb begin
        bit_state_s = bit_state_r;
        case (bit_state_r)
            BIT_IDLE:   if (fall_s) bit_state_s = BIT_START; else bit_state_s = BIT_IDLE;
            BIT_START:  if (at_c_s && rxd_sync_r) bit_state_s = BIT_IDLE;
                        else if (bit_end_s) bit_state_s = BIT_DATA;
                        else bit_state_s = BIT_START;
            BIT_DATA:   if (bit_end_s && (bit_idx_r == last_idx_s))
                            bit_state_s = mode_r[MODE_PAR_EN] ? BIT_PARITY : BIT_STOP1;
                        else bit_state_s = BIT_DATA;
            BIT_PARITY: if (bit_end_s) bit_state_s = BIT_STOP1; else bit_state_s = BIT_PARITY;
            BIT_STOP1:  if (at_c_s && mode_r[MODE_ONE_STOP]) bit_state_s = BIT_IDLE;
                        else if (bit_end_s) bit_state_s = BIT_STOP2;
                        else bit_state_s = BIT_STOP1;
            BIT_STOP2:  if (at_c_s) bit_state_s = BIT_IDLE; else bit_state_s = BIT_STOP2;
            default:    bit_state_s = BIT_IDLE;
        endcase
    end

    // Frame datapath: tick phase, majority samples, assembled byte and error bits.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_r     <= 8'h00;
            tick_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            data_r     <= 8'h00;
            samp_a_r   <= 1'b1;
            samp_c_r   <= 1'b1;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else if (start_s) begin
            mode_r     <= Mode;
            tick_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            data_r     <= 8'h00;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else if (tick_s) begin
            tick_cnt_r <= bit_end_s ? {CW{1'b0}} : tick_cnt_r + CW'(1);
            if (at_a_s) samp_a_r <= rxd_sync_r;
            if (at_c_s) samp_c_r <= rxd_sync_r;
            if (at_b_s && (bit_state_r == BIT_DATA)) data_r[bit_idx_r] <= maj_s;
            if (at_b_s && (bit_state_r == BIT_PARITY))
                perr_r <= parity_error(data_r, maj_s, mode_r[MODE_PAR_ODD]);
            if (at_c_s && (bit_state_r == BIT_STOP1)) ferr_r <= ~rxd_sync_r;
            if (bit_end_s && (bit_state_r == BIT_DATA)) bit_idx_r <= bit_idx_r + 3'd1;
        end
    end

    // Packet FSM and holding register next values.
    always_comb begin
        pkt_state_s = pkt_state_r;
        len_s       = len_r;
        dout_s      = dout_r;
        last_s      = last_r;
        perr_o_s    = perr_o_r;
        ferr_o_s    = ferr_o_r;
        overrun_s   = 1'b0;
        final_s     = (len_r == LEN_W'(1));
        if (valid_r && Ready) valid_s = 1'b0;
        else                  valid_s = valid_r;
        if (done_s) begin
            case (pkt_state_r)
                PKT_HDR_LO: begin
                    if (bad_s) begin
                        pkt_state_s = PKT_HDR_LO;
                    end else begin
                        len_s       = LEN_W'(data_r);
                        pkt_state_s = PKT_HDR_HI;
                    end
                end
                PKT_HDR_HI: begin
                    if (bad_s) begin
                        pkt_state_s = PKT_HDR_LO;
                    end else begin
                        len_s       = LEN_W'({data_r, len_r[7:0]});
                        pkt_state_s = (len_s == LEN_W'(0)) ? PKT_HDR_LO : PKT_PAYLOAD;
                    end
                end
                PKT_PAYLOAD: begin
                    len_s       = len_r - LEN_W'(1);
                    pkt_state_s = final_s ? PKT_HDR_LO : PKT_PAYLOAD;
                    if (!valid_r || Ready) begin
                        dout_s   = data_r;
                        valid_s  = 1'b1;
                        last_s   = final_s;
                        perr_o_s = perr_r;
                        ferr_o_s = ferr_s;
                    end else begin
                        // Dropped byte: a held byte inherits Last if the drop ended the packet.
                        overrun_s = 1'b1;
                        last_s    = last_r | final_s;
                    end
                end
                default: pkt_state_s = PKT_HDR_LO;
            endcase
        end else begin
            pkt_state_s = pkt_state_r;
        end
    end

    // Packet state and registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pkt_state_r <= PKT_HDR_LO;
            len_r       <= {LEN_W{1'b0}};
            dout_r      <= 8'h00;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            perr_o_r    <= 1'b0;
            ferr_o_r    <= 1'b0;
            overrun_r   <= 1'b0;
            rts_r       <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            pkt_state_r <= pkt_state_s;
            len_r       <= len_s;
            dout_r      <= dout_s;
            valid_r     <= valid_s;
            last_r      <= last_s;
            perr_o_r    <= perr_o_s;
            ferr_o_r    <= ferr_o_s;
            overrun_r   <= overrun_s;
            rts_r       <= ~valid_s;
            busy_r      <= (bit_state_s != BIT_IDLE);
        end
    end

    assign DATA_OUT   = dout_r;
    assign Valid      = valid_r;
    assign Last       = last_r;
    assign Parity_err = perr_o_r;
    assign Frame_err  = ferr_o_r;
    assign Overrun    = overrun_r;
    assign RTS        = rts_r;
    assign Busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet; a reduced clock rate keeps bit periods short
// (9600 baud = 96 clocks per bit, 57600 baud = 16 clocks per bit).
module tb_uart_rx_packet;

    localparam int BIT_9600  = 96;
    localparam int BIT_57600 = 16;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Mode = 8'h6C;
    logic       RXD = 1'b1;
    logic       Ready = 1'b1;
    logic [7:0] DATA_OUT;
    logic       Valid, Last, Parity_err, Frame_err, Overrun, RTS, Busy;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    int base = 0;
    int ovr0 = 0;
    logic busy_seen = 1'b0;
    logic [10:0] beats[$];

    always #5 Clock = ~Clock;

    uart_rx_packet #(.CLK_HZ(921_600), .OVERSAMPLE(16), .LEN_W(16)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Mode       (Mode),
        .RXD        (RXD),
        .DATA_OUT   (DATA_OUT),
        .Valid      (Valid),
        .Ready      (Ready),
        .Last       (Last),
        .Parity_err (Parity_err),
        .Frame_err  (Frame_err),
        .Overrun    (Overrun),
        .RTS        (RTS),
        .Busy       (Busy)
    );

    // Record accepted beats as {last, parity_err, frame_err, data}.
    always @(negedge Clock) begin
        if (Reset_n && Valid && Ready) beats.push_back({Last, Parity_err, Frame_err, DATA_OUT});
        if (Overrun) ovr_cnt++;
        if (Busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [10:0] exp);
        if (idx < beats.size()) begin
            check(tag, 16'(beats[idx]), 16'(exp));
        end else begin
            total++;
            bad++;
            $error("FAIL %s observed=missing expected=%h", tag, exp);
        end
    endtask

    task automatic hold_bit(input logic v, input int n);
        RXD = v;
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, input int bclk,
                             input logic par_en, input logic par_bit,
                             input int nstop, input logic stop1, input logic stop2);
        hold_bit(1'b0, bclk);
        for (int i = 0; i < nbits; i++) hold_bit(b[i], bclk);
        if (par_en) hold_bit(par_bit, bclk);
        hold_bit(stop1, bclk);
        if (nstop == 2) hold_bit(stop2, bclk);
        hold_bit(1'b1, bclk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},    16'(DATA_OUT),   16'h0000);
        check({tag, "_valid"},   16'(Valid),      16'h0000);
        check({tag, "_last"},    16'(Last),       16'h0000);
        check({tag, "_perr"},    16'(Parity_err), 16'h0000);
        check({tag, "_ferr"},    16'(Frame_err),  16'h0000);
        check({tag, "_overrun"}, 16'(Overrun),    16'h0000);
        check({tag, "_busy"},    16'(Busy),       16'h0000);
        check({tag, "_rts"},     16'(RTS),        16'h0001);
    endtask

    initial begin
        repeat (5) @(negedge Clock);
        check_reset_values("rst");
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock);

        // 8N1 at 9600: header 03 00, payload A5 3C FF
        Mode = 8'h6C;
        base = beats.size();
        send_byte(8'h03, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h00, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'hA5, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h3C, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'hFF, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        check("n81_count", 16'(beats.size() - base), 16'd3);
        check_beat("n81_a5", base,     11'h0A5);
        check_beat("n81_3c", base + 1, 11'h03C);
        check_beat("n81_ff", base + 2, 11'h4FF);

        // 8E1: 07 with wrong parity bit 0, then with correct parity bit 1
        Mode = 8'h6D;
        base = beats.size();
        send_byte(8'h01, 8, BIT_9600, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        send_byte(8'h00, 8, BIT_9600, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h07, 8, BIT_9600, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h01, 8, BIT_9600, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        send_byte(8'h00, 8, BIT_9600, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h07, 8, BIT_9600, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        check("e81_count", 16'(beats.size() - base), 16'd2);
        check_beat("e81_bad_par", base,     11'h607);
        check_beat("e81_good_par", base + 1, 11'h407);

        // 8N2: second stop bit of payload sampled low
        Mode = 8'h4C;
        base = beats.size();
        send_byte(8'h01, 8, BIT_9600, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        send_byte(8'h00, 8, BIT_9600, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        send_byte(8'h55, 8, BIT_9600, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        check("n82_count", 16'(beats.size() - base), 16'd1);
        check_beat("n82_ferr", base, 11'h555);

        // False start: low for 4 oversample ticks only
        base = beats.size();
        busy_seen = 1'b0;
        hold_bit(1'b0, 24);
        hold_bit(1'b1, 120);
        check("false_busy_seen", 16'(busy_seen), 16'h0001);
        check("false_busy_end", 16'(Busy), 16'h0000);
        check("false_valid", 16'(Valid), 16'h0000);
        check("false_count", 16'(beats.size() - base), 16'd0);

        // Overrun: payload 11 22 with Ready low
        Mode = 8'h6C;
        Ready = 1'b0;
        base = beats.size();
        ovr0 = ovr_cnt;
        send_byte(8'h02, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h00, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h11, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        check("ovr_hold_valid", 16'(Valid), 16'h0001);
        check("ovr_hold_rts", 16'(RTS), 16'h0000);
        check("ovr_none_yet", 16'(ovr_cnt - ovr0), 16'd0);
        send_byte(8'h22, 8, BIT_9600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        check("ovr_pulses", 16'(ovr_cnt - ovr0), 16'd1);
        check("ovr_held_data", 16'(DATA_OUT), 16'h0011);
        check("ovr_held_last", 16'(Last), 16'h0001);
        Ready = 1'b1;
        repeat (4) @(negedge Clock);
        check("ovr_count", 16'(beats.size() - base), 16'd1);
        check_beat("ovr_beat", base, 11'h411);
        check("ovr_rts_free", 16'(RTS), 16'h0001);

        // 5N1 at 57600 with reset mid-frame
        Mode = 8'hE0;
        send_byte(8'h02, 5, BIT_57600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h00, 5, BIT_57600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        hold_bit(1'b0, BIT_57600);
        hold_bit(1'b1, BIT_57600);
        hold_bit(1'b1, BIT_57600 / 2);
        Reset_n = 1'b0;
        repeat (5) @(negedge Clock);
        check_reset_values("midrst");
        Reset_n = 1'b1;
        repeat (40) @(negedge Clock);
        base = beats.size();
        send_byte(8'h01, 5, BIT_57600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h00, 5, BIT_57600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_byte(8'h15, 5, BIT_57600, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        check("n51_count", 16'(beats.size() - base), 16'd1);
        check_beat("n51_beat", base, 11'h415);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
